alarm_controller: RTL and testbench

- Downstream consumer of the digital clock's time outputs: seconds[5:0], minutes[5:0], hours[4:0], binary, 24-hour.
- Holds a programmable alarm time (HH:MM) and raises alarm_out when the running time reaches it.
- Supports snooze, stop and disarm, and auto-timeouts an unanswered alarm.
- Feeds the buzzer/LED driver and status display.

---
 rtl/alarm_controller.sv | 151 +++++++++++++++
 tb/tb_alarm_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm controller: watches the running HH:MM:SS time, rings at the programmed
// alarm time and handles snooze, stop, disarm and unanswered-alarm timeout.
module alarm_controller #(
  parameter int unsigned SNOOZE_MIN   = 5,
  parameter int unsigned RING_MAX_MIN = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       set_en,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       arm,
  input  logic       disarm,
  input  logic       snooze,
  input  logic       stop,
  output logic       alarm_out,
  output logic       armed,
  output logic       snoozing,
  output logic       missed,
  output logic       set_err,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes
);

  localparam int unsigned RW = (RING_MAX_MIN < 1) ? 1 : $clog2(RING_MAX_MIN + 1);
  localparam int unsigned SW = (SNOOZE_MIN < 1) ? 1 : $clog2(SNOOZE_MIN + 1);
  localparam logic [RW-1:0] RING_LIMIT = RW'(RING_MAX_MIN);
  localparam logic [SW-1:0] SNZ_LIMIT  = SW'(SNOOZE_MIN);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [RW-1:0] ring_cnt, ring_cnt_n, ring_inc;
  logic [SW-1:0] snz_cnt, snz_cnt_n, snz_inc;
  logic          missed_n;
  logic          set_err_n;
  logic          load;
  logic [5:0]    minutes_d;
  logic          match_d;
  logic          minute_tick;
  logic          match;
  logic          match_edge;
  logic          set_valid;

  assign minute_tick = (minutes != minutes_d);
  assign match       = (hours == alarm_hours) && (minutes == alarm_minutes) &&
                       (seconds == 6'd0);
  assign match_edge  = match & ~match_d;
  assign set_valid   = (set_hours <= 5'd23) && (set_minutes <= 6'd59);

  // Saturating increments: counters never wrap past their limit.
  assign ring_inc = (ring_cnt >= RING_LIMIT) ? ring_cnt : ring_cnt + RW'(1);
  assign snz_inc  = (snz_cnt  >= SNZ_LIMIT)  ? snz_cnt  : snz_cnt  + SW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= DISARMED;
      ring_cnt      <= '0;
      snz_cnt       <= '0;
      missed        <= 1'b0;
      set_err       <= 1'b0;
      alarm_hours   <= '0;
      alarm_minutes <= '0;
      minutes_d     <= '0;
      match_d       <= 1'b0;
    end else begin
      state     <= state_n;
      ring_cnt  <= ring_cnt_n;
      snz_cnt   <= snz_cnt_n;
      missed    <= missed_n;
      set_err   <= set_err_n;
      minutes_d <= minutes;
      match_d   <= match;
      if (load) begin
        alarm_hours   <= set_hours;
        alarm_minutes <= set_minutes;
      end
    end
  end

  // Strobe priority: disarm > valid set > stop > snooze > arm/internal events.
  always_comb begin
    state_n    = state;
    ring_cnt_n = ring_cnt;
    snz_cnt_n  = snz_cnt;
    missed_n   = missed;
    load       = 1'b0;
    set_err_n  = set_en & ~set_valid;
    if (disarm) begin
      state_n  = DISARMED;
      missed_n = 1'b0;
    end else if (set_en && set_valid) begin
      load     = 1'b1;
      missed_n = 1'b0;
      if (state == RINGING || state == SNOOZE) state_n = ARMED;
    end else if (stop) begin
      missed_n = 1'b0;
      if (state == RINGING || state == SNOOZE) state_n = ARMED;
    end else if (snooze && state == RINGING) begin
      state_n   = SNOOZE;
      snz_cnt_n = '0;
    end else begin
      if (arm) missed_n = 1'b0;
      case (state)
        DISARMED: begin
          if (arm) state_n = ARMED;
        end
        ARMED: begin
          if (match_edge) begin
            state_n    = RINGING;
            ring_cnt_n = '0;
          end
        end
        RINGING: begin
          if (minute_tick) begin
            ring_cnt_n = ring_inc;
            if (ring_inc == RING_LIMIT) begin
              state_n  = ARMED;
              missed_n = 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (minute_tick) begin
            snz_cnt_n = snz_inc;
            if (snz_inc == SNZ_LIMIT) begin
              state_n    = RINGING;
              ring_cnt_n = '0;
            end
          end
        end
        default: state_n = DISARMED;
      endcase
    end
  end

  always_comb begin
    alarm_out = (state == RINGING);
    armed     = (state != DISARMED);
    snoozing  = (state == SNOOZE);
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed plan steps followed by random strobes and
// time jumps, checked each cycle against a minute-count reference model.
module tb_alarm_controller;

  localparam int SNZ  = 5;
  localparam int RMAX = 10;
  localparam int M_OFF = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;

  logic       clk, reset;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic       set_en, arm, disarm, snooze, stop;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       alarm_out, armed, snoozing, missed, set_err;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;

  int tests = 0;
  int fails = 0;

  // Reference model: ring/snooze durations measured as differences of a global
  // count of minute changes.
  int m_mode, m_ah, m_am, m_prev_min, tick_total, ring_start, snz_start;
  bit m_missed, m_seterr, m_prev_match;

  alarm_controller #(.SNOOZE_MIN(SNZ), .RING_MAX_MIN(RMAX)) dut (
    .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
    .set_en(set_en), .set_hours(set_hours), .set_minutes(set_minutes),
    .arm(arm), .disarm(disarm), .snooze(snooze), .stop(stop),
    .alarm_out(alarm_out), .armed(armed), .snoozing(snoozing), .missed(missed),
    .set_err(set_err), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = M_OFF; m_ah = 0; m_am = 0; m_prev_min = 0; m_prev_match = 0;
    m_missed = 0; m_seterr = 0; tick_total = 0; ring_start = 0; snz_start = 0;
  endtask

  task automatic model_update();
    bit tick, match, edge_, valid;
    if (!reset) begin
      model_reset();
      return;
    end
    tick  = (int'(minutes) != m_prev_min);
    if (tick) tick_total++;
    match = (int'(hours) == m_ah) && (int'(minutes) == m_am) && (seconds == 0);
    edge_ = match && !m_prev_match;
    valid = (set_hours <= 23) && (set_minutes <= 59);
    m_seterr = set_en && !valid;
    if (disarm) begin
      m_mode = M_OFF; m_missed = 0;
    end else if (set_en && valid) begin
      m_ah = int'(set_hours); m_am = int'(set_minutes); m_missed = 0;
      if (m_mode == M_RING || m_mode == M_SNZ) m_mode = M_ARMED;
    end else if (stop) begin
      m_missed = 0;
      if (m_mode == M_RING || m_mode == M_SNZ) m_mode = M_ARMED;
    end else if (snooze && m_mode == M_RING) begin
      m_mode = M_SNZ; snz_start = tick_total;
    end else begin
      if (arm) m_missed = 0;
      if (m_mode == M_OFF) begin
        if (arm) m_mode = M_ARMED;
      end else if (m_mode == M_ARMED) begin
        if (edge_) begin m_mode = M_RING; ring_start = tick_total; end
      end else if (m_mode == M_RING) begin
        if (tick_total - ring_start >= RMAX) begin m_mode = M_ARMED; m_missed = 1; end
      end else if (tick_total - snz_start >= SNZ) begin
        m_mode = M_RING; ring_start = tick_total;
      end
    end
    m_prev_min   = int'(minutes);
    m_prev_match = match;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("alarm_out", 8'(alarm_out), 8'(m_mode == M_RING));
    chk("armed",     8'(armed),     8'(m_mode != M_OFF));
    chk("snoozing",  8'(snoozing),  8'(m_mode == M_SNZ));
    chk("missed",    8'(missed),    8'(m_missed));
    chk("set_err",   8'(set_err),   8'(m_seterr));
    chk("alarm_hours",   8'(alarm_hours),   8'(m_ah));
    chk("alarm_minutes", 8'(alarm_minutes), 8'(m_am));
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    set_en = 0; arm = 0; disarm = 0; snooze = 0; stop = 0;
    check_all();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours = 5'(h); minutes = 6'(m); seconds = 6'(s);
  endtask

  task automatic advance_minute();
    int m, h;
    m = int'(minutes) + 1; h = int'(hours);
    if (m == 60) begin m = 0; h = (h + 1) % 24; end
    set_time(h, m, ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 59)));
  endtask

  initial begin
    reset = 0; set_en = 0; arm = 0; disarm = 0; snooze = 0; stop = 0;
    set_hours = 0; set_minutes = 0;
    set_time(7, 0, 0);
    model_reset();
    #1;
    step(); step();
    reset = 1;
    step();

    // Plan 1: load 07:30, arm, ring at 07:30:00
    set_en = 1; set_hours = 5'd7; set_minutes = 6'd30; step();
    arm = 1; step();
    set_time(7, 29, 59); step();
    set_time(7, 30, 0); step();
    chk("p1_ring", 8'(alarm_out), 8'd1);

    // Plan 2: snooze, five minute changes, ring again
    snooze = 1; step();
    chk("p2_snoozing", 8'(snoozing), 8'd1);
    for (int i = 31; i <= 35; i++) begin
      repeat ($urandom_range(0, 2)) step();
      set_time(7, i, int'($urandom_range(0, 59))); step();
    end
    chk("p2_reringing", 8'(alarm_out), 8'd1);

    // Plan 3: ten unanswered minute changes time out, stop clears missed
    for (int i = 36; i <= 45; i++) begin
      repeat ($urandom_range(0, 2)) step();
      set_time(7, i, 0); step();
    end
    chk("p3_missed", 8'(missed), 8'd1);
    stop = 1; step();
    chk("p3_missed_clr", 8'(missed), 8'd0);

    // Plan 4: out-of-range set
    set_en = 1; set_hours = 5'd24; set_minutes = 6'd10; step();
    chk("p4_set_err", 8'(set_err), 8'd1);
    step();
    set_en = 1; set_hours = 5'd7; set_minutes = 6'(60 + $urandom_range(0, 3)); step();
    step();

    // Plan 5: disarm beats snooze; arming during match does not ring
    set_time(7, 29, 59); step();
    set_time(7, 30, 0); step();
    disarm = 1; snooze = 1; step();
    arm = 1; step();
    repeat (4) step();
    chk("p5_no_ring", 8'(alarm_out), 8'd0);
    set_time(7, 31, 0); step();
    set_time(7, 29, 59); step();
    set_time(7, 30, 0); step();

    // Plan 6: asynchronous reset mid-ring
    #2 reset = 0;
    #1 model_reset();
    check_all();
    step();
    reset = 1;
    step();

    // Randomized phase
    set_en = 1; set_hours = 5'($urandom_range(0, 23)); set_minutes = 6'($urandom_range(0, 59));
    step();
    arm = 1; step();
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 40) advance_minute();
      else if (r < 46) set_time(m_ah, m_am, 0);
      else if (r < 52) set_time(m_ah, (m_am + 59) % 60, 59);
      arm    = ($urandom_range(0, 99) < 5);
      disarm = ($urandom_range(0, 99) < 2);
      snooze = ($urandom_range(0, 99) < 8);
      stop   = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 3) begin
        set_en = 1;
        set_hours = 5'($urandom_range(0, 31));
        set_minutes = 6'($urandom_range(0, 63));
      end
      step();
    end

    // Midnight rollover counts as one tick and matches 00:00
    disarm = 1; step();
    set_en = 1; set_hours = 5'd0; set_minutes = 6'd0; step();
    arm = 1; step();
    set_time(23, 59, 59); step();
    set_time(0, 0, 0); step();
    chk("rollover_ring", 8'(alarm_out), 8'd1);
    for (int i = 1; i <= RMAX; i++) begin
      set_time(0, i, 0); step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
